nav_position_unit: RTL
======================

NAV_POSITION_UNIT -- requirements
Module: nav_position_unit

Interface
REQ-001 Parameter K, default 16, bit width of each axis position/velocity (two's complement).
REQ-002 Parameter N, default 3, number of axes.
REQ-003 Parameter SPOOL_CYCLES, default 4 (>=1), jump-drive spool-up duration in cycles.
REQ-004 clk  in  1  single clock; all state changes on rising edge.
REQ-005 rst  in  1  reset; synchronous, active-high.
REQ-006 pos_mode  in  4  one-hot: 0001 zero, 0010 sublight (integrate), 0100 hold, 1000 reserved.
REQ-007 velocity  in  N*K  signed per-axis velocity; axis i at bits [i*K +: K].
REQ-008 jump_valid  in  1  jump request qualifier.
REQ-009 jump_position  in  N*K  jump target, same axis packing; sampled only on acceptance.
REQ-010 jump_ready  out  1  unit can accept a jump this cycle.
REQ-011 position  out  N*K  registered current position, same axis packing.
REQ-012 sat  out  N  per-axis flag: last sublight update of that axis clamped.
REQ-013 jump_done  out  1  one-cycle pulse, high in the first cycle position equals a jump target.
REQ-014 mode_err  out  1  registered; high the cycle after pos_mode was not one-hot or was 1000.

Function
REQ-015 States CRUISE, SPOOL, LOAD; position, sat, jump_done, mode_err all registered.
REQ-016 CRUISE, pos_mode 0001: every axis <= 0; sat <= 0.
REQ-017 CRUISE, pos_mode 0010: axis <= sat(axis + velocity) computed at K+1 bits, clamped to [-2^(K-1), 2^(K-1)-1]; never wraps; sat[i] <= 1 iff clamped.
REQ-018 CRUISE, pos_mode 0100: position held; sat held.
REQ-019 Illegal pos_mode (not one-hot, or 1000): position and sat held; mode_err <= 1; otherwise mode_err <= 0.
REQ-020 jump_ready = (state == CRUISE) and pos_mode is 0010 or 0100; combinational from state and pos_mode.
REQ-021 Accept = jump_valid and jump_ready; at accept edge: target latched from jump_position, spool counter <= SPOOL_CYCLES-1, state -> SPOOL; position updates per pos_mode that same edge.
REQ-022 SPOOL: position frozen regardless of pos_mode (except 0001); sat held; counter decrements each edge; at counter == 0 -> LOAD.
REQ-023 LOAD: position <= target; sat <= 0; jump_done <= 1 for exactly one cycle; state -> CRUISE.
REQ-024 Latency: accept at edge E0 -> position == target and jump_done == 1 after edge E0+SPOOL_CYCLES+1.
REQ-025 pos_mode 0001 during SPOOL or LOAD aborts: position <= 0, state -> CRUISE, no jump_done, target discarded.
REQ-026 jump_valid while jump_ready low: ignored, no queuing; requester holds jump_valid until accepted.
REQ-027 Illegal pos_mode during SPOOL: spool continues, mode_err asserted.

Reset
REQ-028 rst high at edge: state CRUISE, counter 0, position 0, target 0, sat 0, jump_done 0, mode_err 0; overrides all other inputs including mid-spool.
REQ-029 jump_ready low while rst high.

Structure
REQ-030 Shared package nav_pkg holds pos_mode encodings, state encoding, and the saturating-add function.
REQ-031 Sub-module nav_axis_accum: one axis register with saturating adder, load, clear and hold controls; instantiated N times by generate.
REQ-032 FSM and spool counter live once in nav_position_unit, shared by all axes.

Verification (K=16, N=3, SPOOL_CYCLES=4)
REQ-033 rst, then pos_mode 0010, velocity (1,1,1) for 5 edges -> position (5,5,5), sat 000.
REQ-034 From (5,5,5), velocity y = -20, one edge -> position (6,-15,6).
REQ-035 pos_mode 0010, jump_valid with target (100,100,100) accepted at E0 -> position frozen E1..E4, jump_ready low, (100,100,100) and jump_done=1 after E5, jump_done 0 after E6.
REQ-036 x=32760 vx=10 -> x=32767, sat[0]=1; y=-32760 vy=-10 -> y=-32768, sat[1]=1; next update without clamp clears the flags.
REQ-037 Jump accepted, pos_mode 0001 at second SPOOL cycle -> position (0,0,0) next edge, no jump_done, jump_ready high following cycle; repeat with rst instead -> identical result.
REQ-038 pos_mode 0110 for 2 edges -> position held, mode_err=1, jump_ready=0; pos_mode 0010 restores mode_err=0 after one edge.

Source files
------------

// File: rtl/nav_pkg.sv
// Shared definitions for the navigation position unit: mode encodings,
// controller state type and the saturating accumulate helper.
package nav_pkg;

  localparam logic [3:0] MODE_ZERO = 4'b0001;
  localparam logic [3:0] MODE_SUB  = 4'b0010;
  localparam logic [3:0] MODE_HOLD = 4'b0100;
  localparam logic [3:0] MODE_RSVD = 4'b1000;

  typedef enum logic [1:0] {
    ST_CRUISE,
    ST_SPOOL,
    ST_LOAD
  } nav_state_t;

  // Working width of the saturating adder; axis widths up to SAT_W-1 are supported.
  localparam int unsigned SAT_W = 64;

  function automatic logic mode_legal(input logic [3:0] m);
    return (m == MODE_ZERO) || (m == MODE_SUB) || (m == MODE_HOLD);
  endfunction

  // Returns {clamped_flag, result}; result is clamped to the signed range of k bits.
  function automatic logic [SAT_W:0] sat_add(input logic signed [SAT_W-1:0] a,
                                             input logic signed [SAT_W-1:0] b,
                                             input int unsigned             k);
    logic signed [SAT_W:0] sum;
    logic signed [SAT_W:0] hi;
    logic signed [SAT_W:0] lo;
    sum = a + b;
    hi  = (65'sd1 <<< (k - 1)) - 65'sd1;
    lo  = -(65'sd1 <<< (k - 1));
    if (sum > hi)      return {1'b1, hi[SAT_W-1:0]};
    else if (sum < lo) return {1'b1, lo[SAT_W-1:0]};
    else               return {1'b0, sum[SAT_W-1:0]};
  endfunction

endpackage

// File: rtl/nav_axis_accum.sv
// One position axis: register with saturating velocity add, load and clear.
module nav_axis_accum
  import nav_pkg::*;
#(
  parameter int unsigned K = 16
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_clear,
  input  logic         i_load,
  input  logic         i_add,
  input  logic [K-1:0] i_vel,
  input  logic [K-1:0] i_load_val,
  output logic [K-1:0] o_pos,
  output logic         o_sat
);

  logic [K-1:0]       r_pos;
  logic               r_sat;
  logic [SAT_W:0]     w_sum;
  logic [SAT_W-1:K]   w_unused_hi;

  assign w_sum       = sat_add(SAT_W'($signed(r_pos)), SAT_W'($signed(i_vel)), K);
  assign w_unused_hi = w_sum[SAT_W-1:K];

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clear) begin
      r_pos <= '0;
      r_sat <= 1'b0;
    end else if (i_load) begin
      r_pos <= i_load_val;
      r_sat <= 1'b0;
    end else if (i_add) begin
      r_pos <= w_sum[K-1:0];
      r_sat <= w_sum[SAT_W];
    end
  end

  assign o_pos = r_pos;
  assign o_sat = r_sat;

endmodule

// File: rtl/nav_position_unit.sv
// N-axis position integrator with a spooled jump: the FSM and spool counter
// are shared, each axis is a nav_axis_accum instance.
module nav_position_unit
  import nav_pkg::*;
#(
  parameter int unsigned K            = 16,
  parameter int unsigned N            = 3,
  parameter int unsigned SPOOL_CYCLES = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [3:0]     pos_mode,
  input  logic [N*K-1:0] velocity,
  input  logic           jump_valid,
  input  logic [N*K-1:0] jump_position,
  output logic           jump_ready,
  output logic [N*K-1:0] position,
  output logic [N-1:0]   sat,
  output logic           jump_done,
  output logic           mode_err
);

  localparam int unsigned   CW         = (SPOOL_CYCLES > 1) ? $clog2(SPOOL_CYCLES) : 1;
  localparam logic [CW-1:0] SPOOL_LAST = CW'(SPOOL_CYCLES - 1);

  nav_state_t     r_state, w_state_next;
  logic [CW-1:0]  r_cnt, w_cnt_next;
  logic [N*K-1:0] r_target;
  logic           r_jump_done, r_mode_err;
  logic           w_zero, w_accept, w_clear, w_add, w_load, w_done_next;

  assign w_zero     = (pos_mode == MODE_ZERO);
  assign jump_ready = !rst && (r_state == ST_CRUISE) &&
                      ((pos_mode == MODE_SUB) || (pos_mode == MODE_HOLD));
  assign w_accept   = jump_valid && jump_ready;

  // Zero mode takes priority in every state; in SPOOL/LOAD it aborts the jump.
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_clear      = 1'b0;
    w_add        = 1'b0;
    w_load       = 1'b0;
    w_done_next  = 1'b0;
    case (r_state)
      ST_CRUISE: begin
        w_clear = w_zero;
        w_add   = (pos_mode == MODE_SUB);
        if (w_accept) begin
          w_state_next = ST_SPOOL;
          w_cnt_next   = SPOOL_LAST;
        end
      end
      ST_SPOOL: begin
        if (w_zero) begin
          w_clear      = 1'b1;
          w_state_next = ST_CRUISE;
          w_cnt_next   = '0;
        end else if (r_cnt == '0) begin
          w_state_next = ST_LOAD;
        end else begin
          w_cnt_next = r_cnt - CW'(1);
        end
      end
      ST_LOAD: begin
        w_state_next = ST_CRUISE;
        if (w_zero) begin
          w_clear = 1'b1;
        end else begin
          w_load      = 1'b1;
          w_done_next = 1'b1;
        end
      end
      default: w_state_next = ST_CRUISE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_CRUISE;
      r_cnt       <= '0;
      r_target    <= '0;
      r_jump_done <= 1'b0;
      r_mode_err  <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_cnt       <= w_cnt_next;
      if (w_accept) r_target <= jump_position;
      r_jump_done <= w_done_next;
      r_mode_err  <= !mode_legal(pos_mode);
    end
  end

  for (genvar gi = 0; gi < N; gi++) begin : g_axis
    nav_axis_accum #(.K(K)) u_axis (
      .i_clk      (clk),
      .i_rst      (rst),
      .i_clear    (w_clear),
      .i_load     (w_load),
      .i_add      (w_add),
      .i_vel      (velocity[gi*K +: K]),
      .i_load_val (r_target[gi*K +: K]),
      .o_pos      (position[gi*K +: K]),
      .o_sat      (sat[gi])
    );
  end

  assign jump_done = r_jump_done;
  assign mode_err  = r_mode_err;

endmodule
